// File: rtl/postprocess_scheduler.sv
// postprocess_scheduler: sequences the post-processing datapath and buffers its results in a 2-entry FIFO
module postprocess_scheduler #(
    parameter int ITER_LAST   = 511,
    parameter int NUM_RESULTS = 1,
    parameter int DRAIN_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        pp_en,
    output logic [4:0]  pp_cnt,
    output logic [3:0]  pp_pos,
    output logic [8:0]  buf_rd_addr,
    input  logic        pp_valid,
    input  logic [31:0] pp_float0,
    input  logic [31:0] pp_float1,
    output logic        res_valid,
    output logic [31:0] res_data0,
    output logic [31:0] res_data1,
    input  logic        res_ready
);
    localparam logic [8:0] LAST = 9'(ITER_LAST);
    localparam logic [3:0] NRES = 4'(NUM_RESULTS);
    localparam logic [8:0] DMAX = 9'(DRAIN_MAX);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FLUSH, DONE} state_t;

    state_t      state, state_nx;
    logic [8:0]  iter;
    logic [3:0]  res_cnt, res_cnt_nx;
    logic [7:0]  drain_cnt;
    logic [63:0] mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  fifo_count;
    logic        push, pop, timeout, err_set;

    assign pp_cnt      = iter[4:0];
    assign pp_pos      = iter[8:5];
    assign buf_rd_addr = iter;
    assign res_valid   = fifo_count != 2'd0;
    assign res_data0   = mem[rd_ptr][31:0];
    assign res_data1   = mem[rd_ptr][63:32];

    // state, run counters and registered status outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            iter      <= '0;
            res_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != IDLE;
            done  <= state_nx == DONE;
            if (state == IDLE && start) begin
                iter      <= '0;
                res_cnt   <= '0;
                drain_cnt <= '0;
                err       <= 1'b0;
            end else begin
                res_cnt <= res_cnt_nx;
                if (state == ISSUE && pp_en && iter != LAST) iter <= iter + 9'd1;
                if (state == DRAIN && pp_en) drain_cnt <= drain_cnt + 8'd1;
                if (err_set) err <= 1'b1;
            end
        end
    end

    // next state; a result reaching the quota in the same cycle as the timeout wins
    always_comb begin
        res_cnt_nx = (push && res_cnt != 4'd15) ? res_cnt + 4'd1 : res_cnt;
        timeout    = pp_en && ({1'b0, drain_cnt} + 9'd1 >= DMAX);
        err_set    = 1'b0;
        state_nx   = state;
        case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: state_nx = (pp_en && iter == LAST) ? DRAIN : ISSUE;
            DRAIN: begin
                err_set  = res_cnt_nx < NRES && timeout;
                state_nx = (res_cnt_nx >= NRES || timeout) ? FLUSH : DRAIN;
            end
            FLUSH: state_nx = fifo_count == 2'd0 ? DONE : FLUSH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath enable stalls on a full FIFO; no path from res_ready
    always_comb begin
        pp_en = (state == ISSUE || state == DRAIN) && fifo_count != 2'd2;
        push  = pp_en && pp_valid;
        pop   = res_valid && res_ready;
    end

    // two-entry result FIFO
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pp_float1, pp_float0};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
